// File: rtl/psd_div_sequencer.sv
// psd_div_sequencer: start/stop sequencer for an iterative divider core with valid/ready operand and result ports.
// Optional DIV_ZERO_CHECK_EN short-circuits zero divisors to an immediate flagged result.
module psd_div_sequencer #(
  parameter int NBITS = 32,
  parameter int ITER_CYCLES = NBITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_dividend,
  input  logic [NBITS-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_quotient,
  output logic [NBITS-1:0] out_rest,
  output logic             out_dbz,
  output logic             busy,
  output logic             div_start,
  output logic             div_stop,
  output logic [NBITS-1:0] div_dividend,
  output logic [NBITS-1:0] div_divisor,
  input  logic [NBITS-1:0] div_quotient,
  input  logic [NBITS-1:0] div_rest
);
  localparam int CW = $clog2(ITER_CYCLES) + 1;
  typedef enum logic [2:0] {IDLE, START, RUN, STOP, CAPT, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] count;
  logic accept, zero;
  assign accept = in_valid && in_ready;
`ifdef DIV_ZERO_CHECK_EN
  assign zero = in_divisor == '0;
`else
  assign zero = 1'b0;
  assign out_dbz = 1'b0;
`endif
  assign in_ready = state == IDLE;
  assign busy = !in_ready;
  assign div_start = state == START;
  assign div_stop = state == STOP;
  assign out_valid = state == DONE;
  always_comb begin
    next = state;
    case (state)
      IDLE:  next = accept ? (zero ? DONE : START) : IDLE;
      START: next = ITER_CYCLES == 1 ? STOP : RUN;
      // RUN spans ITER_CYCLES-1 cycles so STOP lands ITER_CYCLES after START
      RUN:   next = count == CW'(1) ? STOP : RUN;
      STOP:  next = CAPT;
      CAPT:  next = DONE;
      DONE:  next = out_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      div_dividend <= '0;
      div_divisor <= '0;
      out_quotient <= '0;
      out_rest <= '0;
    end else begin
      state <= next;
      if (accept) begin
        div_dividend <= in_dividend;
        div_divisor <= in_divisor;
      end
      if (state == START) count <= CW'(ITER_CYCLES - 1);
      else if (state == RUN) count <= count - CW'(1);
      if (state == CAPT) begin
        out_quotient <= div_quotient;
        out_rest <= div_rest;
      end
`ifdef DIV_ZERO_CHECK_EN
      if (accept && zero) begin
        out_quotient <= '1;
        out_rest <= in_dividend;
      end
`endif
    end
  end
`ifdef DIV_ZERO_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) out_dbz <= 1'b0;
    else if (accept) out_dbz <= zero;
  end
`endif
endmodule

// File: tb/tb_psd_div_sequencer.sv
// tb_psd_div_sequencer: table-driven check of psd_div_sequencer timing and results with a behavioural core.
module tb_psd_div_sequencer;
  localparam int ITER = 32;
  logic clock = 0, reset = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, out_dbz, busy, div_start, div_stop;
  logic [31:0] in_dividend = 0, in_divisor = 0, out_quotient, out_rest;
  logic [31:0] div_dividend, div_divisor, div_quotient = 0, div_rest = 0;
  int checks = 0, errors = 0;

  psd_div_sequencer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .out_valid(out_valid),
    .out_ready(out_ready), .out_quotient(out_quotient), .out_rest(out_rest),
    .out_dbz(out_dbz), .busy(busy), .div_start(div_start), .div_stop(div_stop),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_rest(div_rest)
  );

  always #5 clock = ~clock;

  // core stand-in: garbage while iterating, result only after stop
  always_ff @(posedge clock) begin
    if (div_start) begin
      div_quotient <= 32'hDEADBEEF;
      div_rest <= 32'hDEADBEEF;
    end else if (div_stop) begin
      div_quotient <= div_divisor == 0 ? 32'hFFFFFFFF : div_dividend / div_divisor;
      div_rest <= div_divisor == 0 ? div_dividend : div_dividend % div_divisor;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    check("ready_timeout", {31'b0, in_ready}, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    check("valid_timeout", {31'b0, out_valid}, 1);
  endtask

  task automatic handshake(input logic [31:0] eq);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("valid_drop", {31'b0, out_valid}, 0);
    check("ready_back", {31'b0, in_ready}, 1);
    check("q_retained", out_quotient, eq);
  endtask

  task automatic run_div(input logic [31:0] dd, input logic [31:0] dv, input logic [31:0] eq,
                         input logic [31:0] er, input int hold, input bit inject);
    bit zp;
    int lat, starts, stops, both, fs, fp, fv, hold_bad, rdy_bad, hb;
`ifdef DIV_ZERO_CHECK_EN
    zp = dv == 0;
`else
    zp = 0;
`endif
    lat = zp ? 1 : ITER + 3;
    {starts, stops, both, fs, fp, fv, hold_bad, rdy_bad, hb} = '0;
    wait_ready();
    in_dividend = dd;
    in_divisor = dv;
    in_valid = 1;
    tick();
    in_valid = 0;
    for (int s = 1; s <= lat; s++) begin
      if (s > 1) tick();
      if (inject && s == 5) begin
        in_valid = 1;
        in_dividend = 50;
        in_divisor = 5;
      end
      if (inject && s == 6) in_valid = 0;
      if (div_start) begin starts++; if (fs == 0) fs = s; end
      if (div_stop) begin stops++; if (fp == 0) fp = s; end
      if (div_start && div_stop) both++;
      if (out_valid && fv == 0) fv = s;
      if (div_dividend !== dd || div_divisor !== dv) hold_bad++;
      if (in_ready || !busy) rdy_bad++;
    end
    check("valid_lat", fv, lat);
    check("start_cnt", starts, zp ? 0 : 1);
    check("start_cyc", fs, zp ? 0 : 1);
    check("stop_cnt", stops, zp ? 0 : 1);
    check("stop_cyc", fp, zp ? 0 : ITER + 1);
    check("start_stop_overlap", both, 0);
    check("operand_hold", hold_bad, 0);
    check("ready_while_busy", rdy_bad, 0);
    check("quotient", out_quotient, eq);
    check("rest", out_rest, er);
    check("dbz", {31'b0, out_dbz}, {31'b0, zp});
    for (int h = 0; h < hold; h++) begin
      tick();
      if (!out_valid || out_quotient !== eq || out_rest !== er) hb++;
    end
    check("backpressure_hold", hb, 0);
    handshake(eq);
  endtask

  typedef struct {
    logic [31:0] dd, dv, q, r;
    int hold;
    bit inject;
  } vec_t;
  vec_t v[6];

  initial begin
    v[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 0, 0};
    v[1] = '{32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 10, 0};
    v[2] = '{32'd100, 32'd7, 32'd14, 32'd2, 0, 1};
    v[3] = '{32'd42, 32'd0, 32'hFFFFFFFF, 32'd42, 3, 0};
    v[4] = '{32'd0, 32'd5, 32'd0, 32'd0, 0, 0};
    v[5] = '{32'd5, 32'd9, 32'd0, 32'd5, 0, 0};
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_outs", {26'b0, out_valid, busy, div_start, div_stop, out_dbz, 1'b0}, 0);
    check("rst_regs", out_quotient | out_rest | div_dividend | div_divisor, 0);
    @(negedge clock) reset = 0;
    tick();
    // reset asserted mid-RUN
    in_dividend = 77;
    in_divisor = 3;
    in_valid = 1;
    tick();
    in_valid = 0;
    repeat (5) @(posedge clock);
    #2 reset = 1;
    #1;
    check("midrun_rst_ready", {31'b0, in_ready}, 1);
    check("midrun_rst_outs", {28'b0, out_valid, busy, div_start, div_stop}, 0);
    check("midrun_rst_operand", div_dividend, 0);
    @(negedge clock) reset = 0;
    tick();
    for (int i = 0; i < 6; i++) run_div(v[i].dd, v[i].dv, v[i].q, v[i].r, v[i].hold, v[i].inject);
    // back-to-back with in_valid held high across the first result handshake
    wait_ready();
    in_dividend = 9;
    in_divisor = 3;
    in_valid = 1;
    tick();
    in_dividend = 8;
    in_divisor = 5;
    wait_valid();
    check("b2b_first_operand", div_dividend, 9);
    check("b2b_first_q", out_quotient, 3);
    check("b2b_first_r", out_rest, 0);
    handshake(3);
    tick();
    in_valid = 0;
    check("b2b_second_accept", {31'b0, busy}, 1);
    check("b2b_second_operand", div_dividend, 8);
    wait_valid();
    check("b2b_second_q", out_quotient, 1);
    check("b2b_second_r", out_rest, 3);
    handshake(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
